// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-stage definitions: block geometry, zigzag scan tables,
// the run-length FSM states and the token format produced by the encoder.
package jpeg_pkg;

    localparam int BLOCK_SIZE  = 8;
    localparam int COEFF_WIDTH = 52;
    localparam int RUN_WIDTH   = 6;

    localparam int IDX_WIDTH   = $clog2(BLOCK_SIZE);
    localparam int ZZ_LEN      = BLOCK_SIZE * BLOCK_SIZE;
    localparam int K_WIDTH     = $clog2(ZZ_LEN);
    localparam logic [K_WIDTH-1:0] ZZ_LAST = K_WIDTH'(ZZ_LEN - 1);

    // Standard JPEG zigzag scan: entry k gives the (row, col) visited at step k.
    localparam int ZZ_ROW [ZZ_LEN] = '{
        0, 0, 1, 2, 1, 0, 0, 1, 2, 3, 4, 3, 2, 1, 0, 0,
        1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 0, 1, 2, 3,
        4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 2, 3, 4, 5, 6,
        7, 7, 6, 5, 4, 3, 4, 5, 6, 7, 7, 6, 5, 6, 7, 7
    };

    localparam int ZZ_COL [ZZ_LEN] = '{
        0, 1, 0, 0, 1, 2, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5,
        4, 3, 2, 1, 0, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4,
        3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3,
        2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 5, 6, 7, 7, 6, 7
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EOB  = 2'd2
    } rle_state_t;

    typedef struct packed {
        logic                          eob;
        logic [RUN_WIDTH-1:0]          run;
        logic signed [COEFF_WIDTH-1:0] level;
    } rle_token_t;

endpackage

// File: rtl/zigzag_lut.sv
// Combinational zigzag address generator: scan index k -> (row, col).
module zigzag_lut
    import jpeg_pkg::*;
(
    input  logic [K_WIDTH-1:0]   i_k,
    output logic [IDX_WIDTH-1:0] o_row,
    output logic [IDX_WIDTH-1:0] o_col
);

    // Table lookup into the package zigzag order.
    always_comb begin
        o_row = IDX_WIDTH'(ZZ_ROW[i_k]);
        o_col = IDX_WIDTH'(ZZ_COL[i_k]);
    end

endmodule

// File: rtl/zigzag_rle.sv
// Zigzag scan + run-length tokenizer for one quantized 8x8 block.
// A block is buffered on accept, then walked in zigzag order one coefficient
// per free output slot; DC is always emitted, AC zeros are counted into runs,
// trailing zeros are dropped and a single EOB token closes the block.
// The token register uses the package widths, so parameter overrides must
// stay consistent with jpeg_pkg (the zigzag tables are fixed at 8x8).
module zigzag_rle #(
    parameter int BLOCK_SIZE  = jpeg_pkg::BLOCK_SIZE,
    parameter int COEFF_WIDTH = jpeg_pkg::COEFF_WIDTH,
    parameter int RUN_WIDTH   = jpeg_pkg::RUN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [COEFF_WIDTH-1:0] in_coeffs [BLOCK_SIZE][BLOCK_SIZE],
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [RUN_WIDTH-1:0]          out_run,
    output logic signed [COEFF_WIDTH-1:0] out_level,
    output logic                          out_eob
);

    import jpeg_pkg::rle_state_t;
    import jpeg_pkg::rle_token_t;
    import jpeg_pkg::IDLE;
    import jpeg_pkg::SCAN;
    import jpeg_pkg::EOB;
    import jpeg_pkg::K_WIDTH;
    import jpeg_pkg::IDX_WIDTH;
    import jpeg_pkg::ZZ_LAST;

    rle_state_t                    r_state, w_stateNext;
    logic [K_WIDTH-1:0]            r_k, w_kNext;
    logic [RUN_WIDTH-1:0]          r_run, w_runNext;
    rle_token_t                    r_tok, w_tokNext;
    logic                          r_outValid, w_outValidNext;
    logic signed [COEFF_WIDTH-1:0] r_block [BLOCK_SIZE][BLOCK_SIZE];

    logic                          w_outFree;
    logic                          w_accept;
    logic [IDX_WIDTH-1:0]          w_row;
    logic [IDX_WIDTH-1:0]          w_col;
    logic signed [COEFF_WIDTH-1:0] w_coeff;

    zigzag_lut u_lut (
        .i_k   (r_k),
        .o_row (w_row),
        .o_col (w_col)
    );

    assign w_outFree = !r_outValid || out_ready;
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_coeff   = r_block[w_row][w_col];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_outValid;
    assign out_run   = r_tok.run;
    assign out_level = r_tok.level;
    assign out_eob   = r_tok.eob;

    // Capture the whole block on accept; contents are don't-care until then.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_block <= in_coeffs;
        end
    end

    // State, scan position, run counter and output token registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_run      <= '0;
            r_tok      <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_k        <= w_kNext;
            r_run      <= w_runNext;
            r_tok      <= w_tokNext;
            r_outValid <= w_outValidNext;
        end
    end

    // Next-state and token generation; a consumed token is retired by default
    // and only replaced when this edge evaluates something worth emitting.
    always_comb begin
        w_stateNext    = r_state;
        w_kNext        = r_k;
        w_runNext      = r_run;
        w_tokNext      = r_tok;
        w_outValidNext = r_outValid && !out_ready;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = SCAN;
                    w_kNext     = '0;
                    w_runNext   = '0;
                end
            end

            SCAN: begin
                if (w_outFree) begin
                    w_kNext = K_WIDTH'(r_k + 1'b1);
                    if (r_k == '0) begin
                        w_tokNext      = '{eob: 1'b0, run: '0, level: w_coeff};
                        w_outValidNext = 1'b1;
                    end else if (w_coeff == '0) begin
                        w_runNext = RUN_WIDTH'(r_run + 1'b1);
                    end else begin
                        w_tokNext      = '{eob: 1'b0, run: r_run, level: w_coeff};
                        w_outValidNext = 1'b1;
                        w_runNext      = '0;
                    end
                    if (r_k == ZZ_LAST) begin
                        w_stateNext = EOB;
                        w_runNext   = '0;
                    end
                end
            end

            EOB: begin
                if (w_outFree) begin
                    if (r_outValid && r_tok.eob) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_tokNext      = '{eob: 1'b1, run: '0, level: '0};
                        w_outValidNext = 1'b1;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule
